hazard_forward_unit: RTL

- Hazard and forwarding controller for the 5-stage 64-bit pipeline. It generates the 2-bit select codes for the two EX-stage operand 3:1 muxes (rs1/rs2 paths).
- It keeps a registered shadow of the destination-register info for the EX, MEM and WB stages. From that shadow it detects load-use hazards, stalls IF/ID and inserts bubbles.
- It also handles branch flushes and counts stall and flush events for performance monitoring.

---
 rtl/hazard_forward_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline: tracks
// destination-register info for EX/MEM/WB, resolves load-use stalls and flushes.
module hazard_forward_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [RA_W-1:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             raw_stall;

  // MEM result is newer than WB, so it wins; x0 and empty EX never forward.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input slot_t ex, input slot_t mem,
                                         input slot_t wb);
    if (!ex.valid)                                                return 2'b00;
    if (mem.valid && mem.regwrite && mem.rd != '0 && mem.rd == rs) return 2'b10;
    if (wb.valid && wb.regwrite && wb.rd != '0 && wb.rd == rs)     return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    forward_a = fwd_sel(ex_rs1_q, ex_q, mem_q, wb_q);
    forward_b = fwd_sel(ex_rs2_q, ex_q, mem_q, wb_q);
  end

  // Conservative: rs2 is compared even if the ID instruction does not read it.
  assign raw_stall = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  // A taken branch squashes the ID instruction anyway, so it overrides the stall.
  assign stall       = raw_stall && !flush;
  assign ex_bubble   = stall || flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ex_d     = '0;
    ex_rs1_d = '0;
    ex_rs2_d = '0;
    if (!ex_bubble) begin
      ex_d.valid    = id_valid;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
    end
    mem_d       = ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = flush ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; the synchronous reset overrides all inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
